// File: rtl/ysyx_23060061_wbu.sv
// Write-back unit: retires one executed instruction at a time.
// For loads, it performs the memory read over the AR/R channel,
// then aligns and extends the returned data. The result is written
// to the register file in the same cycle as the commit handshake.
module ysyx_23060061_wbu #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [31:0]           in_next_pc,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [DATA_WIDTH-1:0] mem_araddr,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [1:0]            mem_rresp,
    output logic                  gpr_wen,
    output logic [ADDR_WIDTH-1:0] gpr_waddr,
    output logic [DATA_WIDTH-1:0] gpr_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_next_pc,
    output logic                  out_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_AR     = 2'd1,
        S_R      = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                  rd_wen_q, rd_wen_d;
    logic                  is_load_q, is_load_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
    logic [31:0]           next_pc_q, next_pc_d;
    logic                  err_q, err_d;

    // A load faults on an illegal width code or a misaligned address.
    function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = off[0];
            3'b010:         bad = (off != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Shift the addressed byte or half down to bit 0, then sign- or zero-extend it.
    function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [2:0]            f3,
                                                          input logic [1:0]            off,
                                                          input logic [DATA_WIDTH-1:0] word);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  res = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b100:  res = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  res = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Next-state logic and capture of the instruction fields and load data.
    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        rd_wen_d  = rd_wen_q;
        is_load_d = is_load_q;
        funct3_d  = funct3_q;
        result_d  = result_q;
        ld_data_d = ld_data_q;
        next_pc_d = next_pc_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d      = in_rd;
                    rd_wen_d  = in_rd_wen;
                    is_load_d = in_is_load;
                    funct3_d  = in_funct3;
                    result_d  = in_result;
                    next_pc_d = in_next_pc;
                    ld_data_d = '0;
                    err_d     = in_is_load & load_fault(in_funct3, in_result[1:0]);
                    if (in_is_load && !load_fault(in_funct3, in_result[1:0])) begin
                        state_d = S_AR;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_AR: begin
                if (mem_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (mem_rvalid) begin
                    ld_data_d = load_extend(funct3_q, result_q[1:0], mem_rdata);
                    err_d     = err_q | (mem_rresp != 2'b00);
                    state_d   = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched-field registers; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            is_load_q <= 1'b0;
            funct3_q  <= '0;
            result_q  <= '0;
            ld_data_q <= '0;
            next_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            rd_wen_q  <= rd_wen_d;
            is_load_q <= is_load_d;
            funct3_q  <= funct3_d;
            result_q  <= result_d;
            ld_data_q <= ld_data_d;
            next_pc_q <= next_pc_d;
            err_q     <= err_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign mem_arvalid = (state_q == S_AR);
    assign mem_araddr  = (state_q == S_AR) ? {result_q[DATA_WIDTH-1:2], 2'b00} : '0;
    assign mem_rready  = (state_q == S_R);
    assign out_valid   = (state_q == S_COMMIT);
    assign out_next_pc = next_pc_q;
    assign out_err     = (state_q == S_COMMIT) & err_q;

    // The write fires only during the accepted commit cycle, so it happens once per instruction.
    assign gpr_wen   = (state_q == S_COMMIT) & out_ready & rd_wen_q & (rd_q != '0) & ~err_q;
    assign gpr_waddr = rd_q;
    assign gpr_wdata = is_load_q ? ld_data_q : result_q;

endmodule

// File: tb/tb_ysyx_23060061_wbu.sv
// Bench for the write-back unit: directed and random instructions
// are checked against a behavioural model of load alignment, faults and timing.
module tb_ysyx_23060061_wbu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [31:0] in_result;
    logic [31:0] in_next_pc;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_araddr;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        gpr_wen;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_next_pc;
    logic        out_err;

    int n_cmp = 0;
    int n_err = 0;
    int wen_seen = 0;

    always #5 clk = ~clk;

    ysyx_23060061_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_is_load(in_is_load),
        .in_funct3(in_funct3), .in_result(in_result), .in_next_pc(in_next_pc),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_next_pc(out_next_pc), .out_err(out_err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Let combinational outputs settle, then record any write pulse seen this cycle.
    task automatic settle();
        #1;
        if (gpr_wen === 1'b1) wen_seen++;
    endtask

    // Model: which loads fault.
    function automatic logic ref_fault(input logic ld, input logic [2:0] f3, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        if (!ld) return 1'b0;
        case (f3)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (off % 2) != 0;
            3'd2:       return off != 0;
            default:    return 1'b1;
        endcase
    endfunction

    // Model: value a legal load writes back.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int unsigned off;
        int unsigned v;
        int unsigned b;
        off = a % 4;
        v = d >> (8 * off);
        case (f3)
            3'd0: begin b = v % 256;   return (b >= 128)   ? b - 256   : b; end
            3'd1: begin b = v % 65536; return (b >= 32768) ? b - 65536 : b; end
            3'd4: return v % 256;
            3'd5: return v % 65536;
            default: return d;
        endcase
    endfunction

    task automatic run_insn(input logic [4:0] rd, input logic wen, input logic ld,
                            input logic [2:0] f3, input logic [31:0] res, input logic [31:0] npc,
                            input logic [31:0] rdata, input logic [1:0] rresp,
                            input int ar_dly, input int r_dly, input int or_dly);
        logic        fault;
        logic        err;
        logic        exp_wen;
        logic [31:0] exp_wd;
        int          w0;
        fault   = ref_fault(ld, f3, res);
        err     = fault | (ld && !fault && rresp != 2'd0);
        exp_wd  = ld ? ref_load(f3, res, rdata) : res;
        exp_wen = wen && (rd != 0) && !err;
        w0      = wen_seen;

        @(negedge clk);
        in_valid = 1'b1; in_rd = rd; in_rd_wen = wen; in_is_load = ld;
        in_funct3 = f3; in_result = res; in_next_pc = npc;
        settle();
        chk("in_ready_idle", in_ready, 1);
        chk("out_valid_idle", out_valid, 0);

        @(negedge clk);
        in_valid = 1'b0; in_rd = 5'($urandom); in_rd_wen = 1'($urandom);
        in_is_load = 1'($urandom); in_funct3 = 3'($urandom);
        in_result = $urandom; in_next_pc = $urandom;
        settle();
        chk("busy_in_ready", in_ready, 0);
        if (ld && !fault) begin
            for (int i = 0; i <= ar_dly; i++) begin
                if (i > 0) @(negedge clk);
                mem_arready = (i == ar_dly);
                settle();
                chk("arvalid", mem_arvalid, 1);
                chk("araddr", mem_araddr, res & 32'hFFFF_FFFC);
                chk("ar_out_valid", out_valid, 0);
            end
            for (int i = 0; i <= r_dly; i++) begin
                @(negedge clk);
                mem_arready = 1'b0;
                mem_rvalid  = (i == r_dly);
                mem_rdata   = (i == r_dly) ? rdata : $urandom;
                mem_rresp   = (i == r_dly) ? rresp : 2'($urandom);
                settle();
                chk("rready", mem_rready, 1);
                chk("r_arvalid", mem_arvalid, 0);
                chk("r_out_valid", out_valid, 0);
            end
            @(negedge clk);
            mem_rvalid = 1'b0; mem_rdata = $urandom; mem_rresp = 2'($urandom);
            settle();
        end else begin
            chk("no_arvalid", mem_arvalid, 0);
        end

        for (int i = 0; i <= or_dly; i++) begin
            if (i > 0) @(negedge clk);
            out_ready = (i == or_dly);
            settle();
            chk("out_valid", out_valid, 1);
            chk("out_next_pc", out_next_pc, npc);
            chk("out_err", out_err, err);
            chk("commit_rready", mem_rready, 0);
            chk("gpr_wen", gpr_wen, (i == or_dly) ? exp_wen : 1'b0);
            chk("gpr_waddr", gpr_waddr, rd);
            if (exp_wen) chk("gpr_wdata", gpr_wdata, exp_wd);
        end

        @(negedge clk);
        out_ready = 1'b0;
        settle();
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
        chk("wen_pulses", wen_seen - w0, exp_wen);
    endtask

    initial begin
        logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        int w0;

        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_is_load = 1'b0;
        in_funct3 = '0; in_result = '0; in_next_pc = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        settle();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_arvalid", mem_arvalid, 0);
        chk("rst_araddr", mem_araddr, 0);
        chk("rst_rready", mem_rready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_gpr_wen", gpr_wen, 0);
        chk("rst_gpr_waddr", gpr_waddr, 0);
        chk("rst_gpr_wdata", gpr_wdata, 0);
        chk("rst_next_pc", out_next_pc, 0);
        chk("rst_out_err", out_err, 0);
        rst = 1'b0;

        // Directed cases
        run_insn(5'd5, 1, 0, 3'd0, 32'h0000_1234, 32'h8000_0004, '0, 2'd0, 0, 0, 0);
        run_insn(5'd7, 1, 1, 3'd0, 32'h8000_0003, 32'h8000_0008, 32'h80FF_7F00, 2'd0, 0, 0, 0);
        run_insn(5'd8, 1, 1, 3'd4, 32'h8000_0003, 32'h8000_000C, 32'h80FF_7F00, 2'd0, 0, 0, 0);
        run_insn(5'd9, 1, 1, 3'd5, 32'h8000_0002, 32'h8000_0010, 32'hBEEF_1234, 2'd0, 0, 0, 0);
        run_insn(5'd10, 1, 1, 3'd2, 32'h8000_0010, 32'h8000_0014, 32'hCAFE_F00D, 2'd0, 3, 2, 4);
        run_insn(5'd11, 1, 1, 3'd1, 32'h8000_0002, 32'h8000_0018, 32'h8001_0000, 2'd0, 1, 1, 0);
        run_insn(5'd12, 1, 1, 3'd2, 32'h8000_0002, 32'h8000_001C, '0, 2'd0, 0, 0, 2);
        run_insn(5'd13, 1, 1, 3'd2, 32'h8000_0020, 32'h8000_0020, 32'h1111_2222, 2'd2, 0, 0, 0);
        run_insn(5'd0, 1, 0, 3'd0, 32'hDEAD_BEEF, 32'h8000_0024, '0, 2'd0, 0, 0, 0);
        run_insn(5'd14, 1, 1, 3'd3, 32'h8000_0000, 32'h8000_0028, '0, 2'd0, 0, 0, 0);
        run_insn(5'd15, 1, 1, 3'd5, 32'h8000_0001, 32'h8000_002C, '0, 2'd0, 0, 0, 0);
        run_insn(5'd16, 0, 0, 3'd0, 32'h0000_5555, 32'h8000_0030, '0, 2'd0, 0, 0, 1);

        // Reset while waiting for read data, with a response arriving alongside reset
        w0 = wen_seen;
        @(negedge clk);
        in_valid = 1'b1; in_rd = 5'd20; in_rd_wen = 1'b1; in_is_load = 1'b1;
        in_funct3 = 3'd2; in_result = 32'h8000_0040; in_next_pc = 32'h8000_0044;
        settle();
        @(negedge clk);
        in_valid = 1'b0; mem_arready = 1'b1;
        settle();
        @(negedge clk);
        mem_arready = 1'b0;
        settle();
        chk("rst_r_rready_before", mem_rready, 1);
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; mem_rresp = 2'd0;
        settle();
        @(negedge clk);
        rst = 1'b0;
        settle();
        chk("rst_r_in_ready", in_ready, 1);
        chk("rst_r_rready", mem_rready, 0);
        chk("rst_r_arvalid", mem_arvalid, 0);
        chk("rst_r_out_valid", out_valid, 0);
        chk("rst_r_waddr", gpr_waddr, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("rst_r_stays_idle", out_valid, 0);
        chk("rst_r_no_write", wen_seen - w0, 0);
        out_ready = 1'b0;

        // Randomized instructions
        for (int k = 0; k < 40; k++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic        ld;
            ld = 1'($urandom);
            f3 = ($urandom % 6 == 0) ? 3'($urandom) : legal_f3[$urandom % 5];
            a  = $urandom;
            if (ld && ($urandom % 4 != 0)) begin
                if (f3 == 3'd2) a[1:0] = 2'b00;
                if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
            end
            run_insn(5'($urandom), 1'($urandom % 4 != 0), ld, f3, a, $urandom, $urandom,
                     ($urandom % 5 == 0) ? 2'($urandom) : 2'd0,
                     $urandom % 4, $urandom % 4, $urandom % 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
